// File: rtl/toggle_decoder.sv
// Toggle-encoded event decoder with a pending-event counter and handshake.
// Each level change on tgl_in_i is one event: it produces a one-cycle pulse, bumps
// a wrap-around total counter and queues one pending event for the consumer.
// Optional build macro TOGGLE_DECODER_SYNC_EN selects a 2-flop synchronizer on
// tgl_in_i; without it the input is registered once (assumed already synchronous).
module toggle_decoder #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PEND_MAX = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tgl_in_i,
    input  logic             clr_i,
    input  logic             evt_ready_i,
    output logic             evt_pulse_o,
    output logic             evt_valid_o,
    output logic [2:0]       pending_o,
    output logic [WIDTH-1:0] count_o,
    output logic             overflow_o,
    output logic             level_o
);

    localparam logic [2:0]       PendMax  = 3'(PEND_MAX);
    localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e           state_q, state_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [2:0]       pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic             tgl_s;
    logic             evt;
    logic             pop;

`ifdef TOGGLE_DECODER_SYNC_EN
    logic sync1_q, sync2_q;

    // Two-flop synchronizer; INIT primes both stages so a high input at reset
    // release does not ripple through as a fake level change.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else if (state_q == StInit) begin
            sync1_q <= tgl_in_i;
            sync2_q <= tgl_in_i;
        end else begin
            sync1_q <= tgl_in_i;
            sync2_q <= sync1_q;
        end
    end

    assign tgl_s = sync2_q;
`else
    logic sync_q;

    // Single input register; the input is already synchronous to clk_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= tgl_in_i;
        end
    end

    assign tgl_s = sync_q;
`endif

    assign evt = (state_q == StRun) && (tgl_s != level_q);
    assign pop = (pending_q != 3'd0) && evt_ready_i;

    // Next-state: FSM, level tracking, event pulse, counters and overflow flag.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        pulse_d    = 1'b0;
        count_d    = count_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;

        unique case (state_q)
            StInit: begin
                // Load the value the synchronizer is being primed with, so the
                // first RUN comparison sees no difference.
                level_d = tgl_in_i;
                state_d = StRun;
            end
            StRun: begin
                if (evt) begin
                    level_d = tgl_s;
                    pulse_d = 1'b1;
                end
            end
            default: state_d = StInit;
        endcase

        if (clr_i) begin
            count_d    = '0;
            pending_d  = 3'd0;
            overflow_d = 1'b0;
        end else begin
            if (evt) begin
                count_d = count_q + CountOne;
            end
            if (evt && !pop) begin
                if (pending_q == PendMax) begin
                    overflow_d = 1'b1;
                end else begin
                    pending_d = pending_q + 3'd1;
                end
            end else if (!evt && pop) begin
                pending_d = pending_q - 3'd1;
            end
        end
    end

    // State registers; reset drops every queued event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StInit;
            level_q    <= 1'b0;
            pulse_q    <= 1'b0;
            count_q    <= '0;
            pending_q  <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            pulse_q    <= pulse_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign evt_pulse_o = pulse_q;
    assign evt_valid_o = (pending_q != 3'd0);
    assign pending_o   = pending_q;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign level_o     = level_q;

endmodule

// File: tb/tb_toggle_decoder.sv
// Scoreboard bench for toggle_decoder (WIDTH=8, PEND_MAX=4).
// Each issued toggle pushes its expected pulse cycle and count; a monitor pops
// and compares whenever evt_pulse_o is seen.
module tb_toggle_decoder;

`ifdef TOGGLE_DECODER_SYNC_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       tgl_in = 1'b1;
    logic       clr = 1'b0;
    logic       evt_ready = 1'b0;
    logic       evt_pulse;
    logic       evt_valid;
    logic [2:0] pending;
    logic [7:0] count;
    logic       overflow;
    logic       level;

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_count = 8'd0;

    toggle_decoder #(
        .WIDTH   (8),
        .PEND_MAX(4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .tgl_in_i   (tgl_in),
        .clr_i      (clr),
        .evt_ready_i(evt_ready),
        .evt_pulse_o(evt_pulse),
        .evt_valid_o(evt_valid),
        .pending_o  (pending),
        .count_o    (count),
        .overflow_o (overflow),
        .level_o    (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (evt_pulse) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_pulse: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_count", {24'd0, count}, {24'd0, e.cnt});
                end
            end else if (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missing_pulse: got none by cycle %0d, expected at %0d",
                         cyc, sb_q[0].cyc);
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic toggle();
        exp_t e;
        @(negedge clk);
        tgl_in = ~tgl_in;
        exp_count = exp_count + 8'd1;
        e.cyc = cyc + 1 + Lat;
        e.cnt = exp_count;
        sb_q.push_back(e);
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_count = 8'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state with tgl_in high.
        #12;
        check("rst_pulse", evt_pulse, 0);
        check("rst_count", count, 0);
        check("rst_pending", pending, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_level", level, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (10) @(negedge clk);
        check("init_level", level, 1);
        check("init_count", count, 0);

        // Three isolated toggles with no consumer.
        for (int i = 0; i < 3; i++) begin
            toggle();
            repeat (4) @(negedge clk);
        end
        check("iso_count", count, 3);
        check("iso_pending", pending, 3);
        check("iso_valid", evt_valid, 1);
        evt_ready = 1'b1;
        repeat (3) @(negedge clk);
        evt_ready = 1'b0;
        check("drain_pending", pending, 0);
        check("drain_valid", evt_valid, 0);

        // Overflow: six events into a 4-deep pending counter.
        clr_pulse();
        for (int i = 0; i < 6; i++) begin
            toggle();
            repeat (3) @(negedge clk);
        end
        check("ovf_pending", pending, 4);
        check("ovf_count", count, 6);
        check("ovf_flag", overflow, 1);
        repeat (3) @(negedge clk);
        check("ovf_sticky", overflow, 1);
        clr_pulse();
        check("clr_count", count, 0);
        check("clr_pending", pending, 0);
        check("clr_overflow", overflow, 0);

        // Full pending with an event coinciding with a pop.
        for (int i = 0; i < 4; i++) begin
            toggle();
            repeat (3) @(negedge clk);
        end
        check("full_pending", pending, 4);
        toggle();
        repeat (Lat) @(negedge clk);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("coinc_pending", pending, 4);
        check("coinc_overflow", overflow, 0);
        check("coinc_count", count, 5);

        // Counter wrap: 257 events with the consumer always ready; clr beats pop.
        evt_ready = 1'b1;
        clr_pulse();
        check("clr_vs_pop_pending", pending, 0);
        for (int i = 0; i < 257; i++) begin
            toggle();
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("wrap_count", count, 1);
        check("wrap_overflow", overflow, 0);
        check("wrap_pending", pending, 0);

        // Back-to-back toggles on consecutive cycles.
        for (int i = 0; i < 4; i++) toggle();
        repeat (5) @(negedge clk);
        check("b2b_count", count, 5);
        check("b2b_pending", pending, 0);

        // Reset in the middle of a burst.
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) toggle();
        #2;
        rst_ni = 1'b0;
        sb_q.delete();
        exp_count = 8'd0;
        #1;
        check("mid_rst_pulse", evt_pulse, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_pending", pending, 0);
        check("mid_rst_valid", evt_valid, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_level", level, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_level", level, {31'd0, tgl_in});
        check("post_rst_count", count, 0);
        check("post_rst_pending", pending, 0);

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/toggle_decoder.md
TOGGLE_DECODER -- requirements
Module: toggle_decoder

Interface
REQ-001 Parameter WIDTH, default 8: width of the total event counter.
REQ-002 Parameter PEND_MAX, default 4: capacity of the pending-event counter (range 1..7).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 tgl_in  input  1  toggle-encoded event line (each level change = one event), asynchronous to clk.
REQ-006 clr  input  1  synchronous clear of count, pending and overflow.
REQ-007 evt_ready  input  1  consumer accepts one pending event.
REQ-008 evt_pulse  output  1  one-cycle pulse per decoded event.
REQ-009 evt_valid  output  1  high while pending != 0.
REQ-010 pending  output  3  number of unacknowledged events.
REQ-011 count  output  WIDTH  total decoded events, modulo 2^WIDTH.
REQ-012 overflow  output  1  sticky: an event was lost because pending was full.
REQ-013 level  output  1  last decoded level of tgl_in.

Function
REQ-014 FSM states INIT and RUN; reset enters INIT; INIT lasts exactly one cycle, then RUN unconditionally.
REQ-015 In INIT the synchronized tgl_in value is loaded into level with no event generated (no spurious event when tgl_in is high at reset release).
REQ-016 In RUN an event is detected when the synchronized tgl_in differs from level; level is then updated to the synchronized value.
REQ-017 evt_pulse is registered: high for exactly one cycle per event, never two events merged; back-to-back toggles on consecutive cycles produce back-to-back pulses.
REQ-018 count increments by 1 on the same edge evt_pulse rises; wraps 2^WIDTH-1 -> 0 with no flag.
REQ-019 Handshake: pop occurs on a rising edge where evt_valid and evt_ready are both high; evt_ready while evt_valid low has no effect.
REQ-020 Event without pop: pending +1; pop without event: pending -1; event and pop together: pending unchanged.
REQ-021 Event with pending == PEND_MAX and no simultaneous pop: pending unchanged, overflow set, count still increments, evt_pulse still asserted.
REQ-022 Event with pending == PEND_MAX and simultaneous pop: pending unchanged, overflow not set.
REQ-023 overflow stays high until clr or reset.
REQ-024 clr high: count, pending, overflow go to 0 next edge; an event on that edge is not counted or queued but evt_pulse and level still update; clr overrides a simultaneous pop.
REQ-025 clr has no effect on FSM state or synchronizer.

Reset
REQ-026 rst low asynchronously forces: state INIT, synchronizer stages 0, level 0, evt_pulse 0, count 0, pending 0, evt_valid 0, overflow 0.
REQ-027 Reset asserted mid-operation discards all pending events; no pulse is emitted on reset release.

Configuration
REQ-028 Macro TOGGLE_DECODER_SYNC_EN defined: tgl_in passes a 2-flop synchronizer; a change first sampled at edge k gives evt_pulse high after edge k+2.
REQ-029 Macro undefined: tgl_in registered once (input already synchronous); change sampled at edge k gives evt_pulse high after edge k+1.
REQ-030 All other behaviour identical in both builds.

Verification
REQ-031 Reset with tgl_in=1, release, hold 10 cycles -> no evt_pulse, level=1, count=0.
REQ-032 Three isolated toggles, evt_ready=0 -> three single-cycle pulses, count=3, pending=3, evt_valid=1; then evt_ready=1 three cycles -> pending=0, evt_valid=0.
REQ-033 PEND_MAX=4, six toggles with evt_ready=0 -> pending=4, count=6, overflow=1; clr -> count=0, pending=0, overflow=0.
REQ-034 pending=4, toggle coincident with pop -> pending=4, overflow=0, count +1.
REQ-035 WIDTH=8, 257 toggles with evt_ready=1 -> count=1, overflow=0.
REQ-036 Both macro builds: single toggle -> pulse latency 3 edges (defined) vs 2 edges (undefined) from first sampling edge; rst low mid-burst -> all outputs 0 immediately.
